onehot_decoder: RTL and testbench



---
 rtl/decoder_pkg.sv | 25 ++
 rtl/code_fifo.sv | 97 +++++++++
 rtl/onehot_decoder.sv | 137 +++++++++++++
 tb/tb_onehot_decoder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// -----------------------------------------------------------------------------
// decoder_pkg
// Shared types and constants for the buffered 2-to-4 one-hot decoder.
//   state_e        : top-level FSM state (IDLE, DRIVE)
//   CODE_W         : width of an encoded index
//   ONEHOT_W       : width of the decoded one-hot word
//   decode_onehot  : maps code n to a word with only bit n set
// -----------------------------------------------------------------------------
package decoder_pkg;

  localparam int CODE_W   = 2;
  localparam int ONEHOT_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRIVE = 1'b1
  } state_e;

  function automatic logic [ONEHOT_W-1:0] decode_onehot(input logic [CODE_W-1:0] code);
    logic [ONEHOT_W-1:0] word;
    word = {{(ONEHOT_W-1){1'b0}}, 1'b1} << code;
    return word;
  endfunction

endpackage

// File: rtl/code_fifo.sv
// -----------------------------------------------------------------------------
// code_fifo
// Circular-buffer FIFO holding encoded indices between the input handshake
// and the decoder FSM. Pointers are $clog2(DEPTH) bits and wrap naturally;
// the occupancy count is one bit wider so "full" is distinguishable.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush_i      : synchronous clear of pointers and count (wins over push/pop)
//   push_i       : write wdata_i (ignored when full)
//   wdata_i      : data to write
//   pop_i        : advance read pointer (ignored when empty)
//   rdata_o      : head entry, valid whenever empty_o is low
//   full_o       : count == DEPTH (registered-state decode)
//   empty_o      : count == 0     (registered-state decode)
// -----------------------------------------------------------------------------
module code_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_en_s;
  logic             pop_en_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign rdata_o   = mem_q[rd_ptr_q];
  assign push_en_s = push_i && !full_o;
  assign pop_en_s  = pop_i && !empty_o;

  // Next-state pointers and count; a simultaneous push and pop cancel in the count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_en_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_en_s, pop_en_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; flush has priority over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; a write presented during flush is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (push_en_s && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/onehot_decoder.sv
// -----------------------------------------------------------------------------
// onehot_decoder
// Buffered 2-to-4 one-hot decoder. Codes arrive over valid/ready, queue in a
// code_fifo, and each is driven on `out` as a one-hot word for HOLD cycles.
// Queued codes issue back-to-back with no zero cycle between words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_code is valid
//   in_ready   : FIFO can accept a code (from registered count only)
//   in_code    : encoded index 0..3
//   flush      : synchronous clear of FIFO, FSM and output
//   out        : registered one-hot word, 4'b0000 when idle
//   out_valid  : registered, high while out carries a word
//   busy       : FIFO non-empty or FSM in DRIVE
// -----------------------------------------------------------------------------
module onehot_decoder
  import decoder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                flush,
  output logic [ONEHOT_W-1:0] out,
  output logic                out_valid,
  output logic                busy
);

  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

  state_e              state_q, state_d;
  logic [ONEHOT_W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [CODE_W-1:0]   fifo_rdata_s;
  logic                push_s;
  logic                pop_s;

  assign in_ready  = !fifo_full_s;
  assign push_s    = in_valid && in_ready;
  assign busy      = !fifo_empty_s || (state_q == DRIVE);
  assign out       = out_q;
  assign out_valid = out_valid_q;

  code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push_s),
    .wdata_i (in_code),
    .pop_i   (pop_s),
    .rdata_o (fifo_rdata_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // FSM next state, hold counter, one-hot load and FIFO pop request.
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    hold_d      = hold_q;
    pop_s       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty_s && !flush) begin
          pop_s       = 1'b1;
          out_d       = decode_onehot(fifo_rdata_s);
          out_valid_d = 1'b1;
          hold_d      = HOLD_LOAD;
          state_d     = DRIVE;
        end else begin
          out_d       = {ONEHOT_W{1'b0}};
          out_valid_d = 1'b0;
          hold_d      = {HOLD_W{1'b0}};
          state_d     = IDLE;
        end
      end
      DRIVE: begin
        out_valid_d = 1'b1;
        if (hold_q != {HOLD_W{1'b0}}) begin
          hold_d = hold_q - HOLD_W'(1);
        end else if (!fifo_empty_s && !flush) begin
          // Last cycle of this word: reload straight from the queue so the
          // next word follows without a zero cycle.
          pop_s   = 1'b1;
          out_d   = decode_onehot(fifo_rdata_s);
          hold_d  = HOLD_LOAD;
          state_d = DRIVE;
        end else begin
          out_d       = {ONEHOT_W{1'b0}};
          out_valid_d = 1'b0;
          hold_d      = {HOLD_W{1'b0}};
          state_d     = IDLE;
        end
      end
      default: begin
        out_d       = {ONEHOT_W{1'b0}};
        out_valid_d = 1'b0;
        hold_d      = {HOLD_W{1'b0}};
        state_d     = IDLE;
      end
    endcase
  end

  // FSM and output registers; flush returns everything to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_q       <= {ONEHOT_W{1'b0}};
      out_valid_q <= 1'b0;
      hold_q      <= {HOLD_W{1'b0}};
    end else if (flush) begin
      state_q     <= IDLE;
      out_q       <= {ONEHOT_W{1'b0}};
      out_valid_q <= 1'b0;
      hold_q      <= {HOLD_W{1'b0}};
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_onehot_decoder.sv
// -----------------------------------------------------------------------------
// tb_onehot_decoder
// Directed bench for onehot_decoder (DEPTH=4, HOLD=3): a vector table for the
// single-code, back-to-back and flush cases, streamed sequences checked
// against an in-order scoreboard, and an asynchronous reset mid-DRIVE.
// -----------------------------------------------------------------------------
module tb_onehot_decoder;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_code;
  logic       flush;
  logic [3:0] out;
  logic       out_valid;
  logic       busy;

  int tests_run;
  int tests_failed;

  onehot_decoder #(
    .DEPTH (DEPTH),
    .HOLD  (HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .flush     (flush),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [1:0] c;
    logic       f;
    logic [3:0] eo;
    logic       ev;
    logic       er;
    logic       eb;
  } vec_t;

  vec_t       vecs[$];
  logic [1:0] sent[$];
  logic [3:0] got[$];
  logic       mon_en;
  int         run;
  logic [3:0] prev_out;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [1:0] c, input logic f,
                     input logic [3:0] eo, input logic ev, input logic er, input logic eb);
    vec_t r;
    r.v = v; r.c = c; r.f = f; r.eo = eo; r.ev = ev; r.er = er; r.eb = eb;
    vecs.push_back(r);
  endtask

  // Collects decoded words and checks each lasts exactly HOLD cycles.
  task automatic monitor();
    if (mon_en) begin
      if (out_valid) begin
        chk("onehot_legal", 8'($countones(out)), 8'd1);
        if (run == 0 || run == HOLD || out != prev_out) begin
          if (run != 0) chk("word_len", 8'(run), 8'(HOLD));
          got.push_back(out);
          run = 1;
        end else begin
          run++;
        end
      end else begin
        chk("idle_out_zero", {4'd0, out}, 8'd0);
        if (run != 0) chk("word_len", 8'(run), 8'(HOLD));
        run = 0;
      end
      prev_out = out;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    monitor();
  endtask

  // Streams sent[] with in_valid held high, then checks decoded order.
  task automatic stream(input string name, output logic saw_full);
    int idx;
    logic acc;
    got.delete();
    run = 0;
    prev_out = 4'd0;
    mon_en = 1'b1;
    idx = 0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (idx >= sent.size() && !busy) break;
      if (idx < sent.size()) begin
        in_valid = 1'b1;
        in_code  = sent[idx];
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      if (!in_ready) saw_full = 1'b1;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    step();
    mon_en = 1'b0;
    chk({name, "_drained"}, {7'd0, busy}, 8'd0);
    chk({name, "_count"}, 8'(got.size()), 8'(sent.size()));
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      logic [3:0] expw;
      expw = 4'b0001 << sent[i];
      chk({name, "_order"}, {4'd0, got[i]}, {4'd0, expw});
    end
  endtask

  initial begin
    logic saw_full;
    tests_run    = 0;
    tests_failed = 0;
    mon_en   = 1'b0;
    run      = 0;
    prev_out = 4'd0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_code  = 2'd0;
    flush    = 1'b0;

    #12;
    chk("rst_out", {4'd0, out}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    rst_n = 1'b1;
    step();

    //   v     c     f     out      ov    rdy   busy
    // single code 2
    add(1'b1, 2'd2, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0100, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    // back-to-back 0,1,3
    add(1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(1'b1, 2'd1, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    add(1'b1, 2'd3, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0001, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    // flush mid-DRIVE with two queued and a code presented in the flush cycle
    add(1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(1'b1, 2'd2, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b1, 2'd3, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1, 1'b0);
    add(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);
    add(1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0010, 1'b1, 1'b1, 1'b1);
    add(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = vecs[i].v;
      in_code  = vecs[i].c;
      flush    = vecs[i].f;
      step();
      chk($sformatf("vec%0d_out", i), {4'd0, out}, {4'd0, vecs[i].eo});
      chk($sformatf("vec%0d_valid", i), {7'd0, out_valid}, {7'd0, vecs[i].ev});
      chk($sformatf("vec%0d_ready", i), {7'd0, in_ready}, {7'd0, vecs[i].er});
      chk($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, vecs[i].eb});
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    step();

    // Full FIFO: 7 codes with in_valid held high
    sent = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd1, 2'd3};
    stream("full", saw_full);
    chk("full_ready_low_seen", {7'd0, saw_full}, 8'd1);

    // Pointer wrap: 10 codes
    sent = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1, 2'd2};
    stream("wrap", saw_full);

    // Async reset mid-DRIVE with one code queued
    in_valid = 1'b1; in_code = 2'd3;
    step();
    in_valid = 1'b1; in_code = 2'd1;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_out", {4'd0, out}, 8'b0000_1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out", {4'd0, out}, 8'd0);
    chk("arst_valid", {7'd0, out_valid}, 8'd0);
    chk("arst_ready", {7'd0, in_ready}, 8'd1);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    #2;
    rst_n = 1'b1;
    step();
    chk("post_rst_lost_out", {4'd0, out}, 8'd0);
    chk("post_rst_lost_busy", {7'd0, busy}, 8'd0);
    in_valid = 1'b1; in_code = 2'd2;
    step();
    in_valid = 1'b0;
    chk("post_rst_push_out", {4'd0, out}, 8'd0);
    chk("post_rst_push_busy", {7'd0, busy}, 8'd1);
    for (int i = 0; i < HOLD; i++) begin
      step();
      chk("post_rst_out", {4'd0, out}, 8'b0000_0100);
      chk("post_rst_valid", {7'd0, out_valid}, 8'd1);
    end
    step();
    chk("post_rst_end_out", {4'd0, out}, 8'd0);
    chk("post_rst_end_busy", {7'd0, busy}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
